// File: rtl/c2c_pkg.sv
// c2c_pkg: shared definitions for the chip-to-chip receive deframer.
//   - framing byte constants (start-of-frame default, training, idle)
//   - parser state enum
//   - FIFO entry layout {err, last, data[7:0]}
package c2c_pkg;

  localparam logic [7:0] SOF_BYTE_DEF = 8'hA5;
  localparam logic [7:0] TRAIN_BYTE   = 8'h0A;
  localparam logic [7:0] IDLE_BYTE    = 8'hFF;

  typedef enum logic [2:0] {
    WAIT_ALIGN,
    HUNT,
    LEN,
    PAYLOAD,
    CHK
  } rx_state_e;

  typedef struct packed {
    logic       err;
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/c2c_fifo_fwft.sv
// c2c_fifo_fwft: first-word-fall-through FIFO with fill-level output.
//   clk, rst     : clock, asynchronous active-high reset (empties the FIFO)
//   wr_en_i      : push wr_data_i (ignored when full)
//   wr_data_i    : entry to push
//   rd_en_i      : pop the head (ignored when empty)
//   rd_data_o    : head entry, valid whenever valid_o is high
//   valid_o      : FIFO non-empty
//   count_o      : current number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module c2c_fifo_fwft #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push, pop;

  assign pop  = rd_en_i && (count_q != '0);
  assign push = wr_en_i && (count_q != CW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: only entries between the pointers are visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign valid_o   = (count_q != '0);
  assign count_o   = count_q;

endmodule

// File: rtl/c2c_rx_deframer.sv
// c2c_rx_deframer: hunts for a start-of-frame byte in the aligned ISERDES
// word stream, parses a length-prefixed frame with an XOR checksum and
// queues payload plus one terminator entry into a FWFT FIFO.
//   clkdiv      : divided link clock (only clock)
//   rst         : asynchronous active-high reset
//   q_in        : aligned 8-bit word, consumed every clkdiv edge
//   align_done  : bit-slip aligner lock; dropping it aborts a frame
//   m_data/m_last/m_err/m_valid/m_ready : FIFO head, valid/ready pop
//   frame_good  : one-cycle pulse, frame accepted
//   frame_bad   : one-cycle pulse, frame rejected (length, checksum,
//                 drop or abort)
//   overflow    : one-cycle pulse per dropped payload byte
//   fifo_count  : FIFO fill level
// Optional: define C2C_RX_STATS_EN to add saturating 16-bit counters
// stat_good / stat_bad / stat_drop of the three pulses.
module c2c_rx_deframer
  import c2c_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter int         MAX_LEN    = 64,
  parameter logic [7:0] SOF_BYTE   = SOF_BYTE_DEF
) (
  input  logic                          clkdiv,
  input  logic                          rst,
  input  logic [7:0]                    q_in,
  input  logic                          align_done,
  output logic [7:0]                    m_data,
  output logic                          m_last,
  output logic                          m_err,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          frame_good,
  output logic                          frame_bad,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef C2C_RX_STATS_EN
  ,
  output logic [15:0]                   stat_good,
  output logic [15:0]                   stat_bad,
  output logic [15:0]                   stat_drop
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rx_state_e   state_q, state_d;
  logic [7:0]  remain_q, remain_d;
  logic [7:0]  chk_q, chk_d;
  logic        pushed_q, pushed_d;
  logic        dropped_q, dropped_d;
  logic        good_q, good_d;
  logic        bad_q, bad_d;
  logic        ovf_q, ovf_d;

  logic        wr_en;
  fifo_entry_t wr_entry;
  fifo_entry_t head;
  logic        room;
  logic        chk_bad;

  // One slot stays reserved so the terminator of a frame that already
  // pushed payload always fits, even after later bytes were dropped.
  assign room = (fifo_count < CW'(FIFO_DEPTH - 1));

  always_ff @(posedge clkdiv or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_ALIGN;
      remain_q  <= '0;
      chk_q     <= '0;
      pushed_q  <= 1'b0;
      dropped_q <= 1'b0;
      good_q    <= 1'b0;
      bad_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      chk_q     <= chk_d;
      pushed_q  <= pushed_d;
      dropped_q <= dropped_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    chk_d     = chk_q;
    pushed_d  = pushed_q;
    dropped_d = dropped_q;
    good_d    = 1'b0;
    bad_d     = 1'b0;
    ovf_d     = 1'b0;
    wr_en     = 1'b0;
    wr_entry  = '0;
    chk_bad   = 1'b0;

    unique case (state_q)
      WAIT_ALIGN: begin
        if (align_done) state_d = HUNT;
      end

      // Idle, training and any other non-SOF bytes are simply skipped.
      HUNT: begin
        if (q_in == SOF_BYTE) begin
          pushed_d  = 1'b0;
          dropped_d = 1'b0;
          state_d   = LEN;
        end
      end

      LEN: begin
        if (!align_done) begin
          // Nothing of this frame is in the FIFO yet, so no terminator.
          bad_d   = 1'b1;
          state_d = WAIT_ALIGN;
        end else if (q_in == 8'h00 || int'(q_in) > MAX_LEN) begin
          bad_d   = 1'b1;
          state_d = HUNT;
        end else begin
          remain_d  = q_in;
          chk_d     = q_in;
          pushed_d  = 1'b0;
          dropped_d = 1'b0;
          state_d   = PAYLOAD;
        end
      end

      PAYLOAD: begin
        if (!align_done) begin
          if (pushed_q) begin
            wr_en         = 1'b1;
            wr_entry.err  = 1'b1;
            wr_entry.last = 1'b1;
          end
          bad_d   = 1'b1;
          state_d = WAIT_ALIGN;
        end else begin
          chk_d    = chk_q ^ q_in;
          remain_d = remain_q - 8'd1;
          if (room) begin
            wr_en         = 1'b1;
            wr_entry.data = q_in;
            pushed_d      = 1'b1;
          end else begin
            ovf_d     = 1'b1;
            dropped_d = 1'b1;
          end
          // remain_q counts bytes still due including this one.
          if (remain_q == 8'd1) state_d = CHK;
        end
      end

      CHK: begin
        if (!align_done) begin
          if (pushed_q) begin
            wr_en         = 1'b1;
            wr_entry.err  = 1'b1;
            wr_entry.last = 1'b1;
          end
          bad_d   = 1'b1;
          state_d = WAIT_ALIGN;
        end else begin
          chk_bad = (q_in != chk_q) || dropped_q;
          if (pushed_q) begin
            wr_en         = 1'b1;
            wr_entry.err  = chk_bad;
            wr_entry.last = 1'b1;
            wr_entry.data = q_in;
          end
          good_d  = !chk_bad;
          bad_d   = chk_bad;
          state_d = HUNT;
        end
      end

      default: state_d = WAIT_ALIGN;
    endcase
  end

  c2c_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clkdiv),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_entry),
    .rd_en_i   (m_ready),
    .rd_data_o (head),
    .valid_o   (m_valid),
    .count_o   (fifo_count)
  );

  assign m_data     = head.data;
  assign m_last     = head.last;
  assign m_err      = head.err;
  assign frame_good = good_q;
  assign frame_bad  = bad_q;
  assign overflow   = ovf_q;

`ifdef C2C_RX_STATS_EN
  logic [15:0] stat_good_q, stat_bad_q, stat_drop_q;

  always_ff @(posedge clkdiv or posedge rst) begin
    if (rst) begin
      stat_good_q <= '0;
      stat_bad_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      if (good_q && stat_good_q != 16'hFFFF) stat_good_q <= stat_good_q + 16'd1;
      if (bad_q  && stat_bad_q  != 16'hFFFF) stat_bad_q  <= stat_bad_q  + 16'd1;
      if (ovf_q  && stat_drop_q != 16'hFFFF) stat_drop_q <= stat_drop_q + 16'd1;
    end
  end

  assign stat_good = stat_good_q;
  assign stat_bad  = stat_bad_q;
  assign stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_c2c_rx_deframer.sv
// Scoreboard bench for c2c_rx_deframer. The driver feeds one byte per
// clkdiv edge tagged with its role in the frame; a frame-level model turns
// roles into expected FIFO entries (queued), expected pulses and the
// expected fill level. A negedge monitor compares all of them.
module tb_c2c_rx_deframer;

  localparam int         DEPTH = 16;
  localparam int         MAXL  = 64;
  localparam logic [7:0] SOF   = 8'hA5;

  logic       clkdiv = 1'b0;
  logic       rst;
  logic [7:0] q_in;
  logic       align_done;
  logic [7:0] m_data;
  logic       m_last, m_err, m_valid, m_ready;
  logic       frame_good, frame_bad, overflow;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef C2C_RX_STATS_EN
  logic [15:0] stat_good, stat_bad, stat_drop;
`endif

  always #5 clkdiv = ~clkdiv;

  c2c_rx_deframer #(.FIFO_DEPTH(DEPTH), .MAX_LEN(MAXL), .SOF_BYTE(SOF)) dut (
    .clkdiv     (clkdiv),
    .rst        (rst),
    .q_in       (q_in),
    .align_done (align_done),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_err      (m_err),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .frame_good (frame_good),
    .frame_bad  (frame_bad),
    .overflow   (overflow),
    .fifo_count (fifo_count)
`ifdef C2C_RX_STATS_EN
    ,
    .stat_good  (stat_good),
    .stat_bad   (stat_bad),
    .stat_drop  (stat_drop)
`endif
  );

  typedef enum int {R_IGN, R_SOF, R_LEN, R_LENBAD, R_PAY, R_CHK, R_ABORT} role_e;
  typedef struct packed { logic err; logic last; logic [7:0] data; } ent_t;

  ent_t       exp_q[$];
  logic [7:0] pay_q[$];
  int         mcount = 0;
  bit         f_pushed, f_dropped;
  logic [7:0] f_sum;
  bit         exp_good = 0, exp_bad = 0, exp_ovf = 0;
  int         tot_good = 0, tot_bad = 0, tot_ovf = 0;
  int         rdy_mode = 0;
  bit         mon_en = 0;
  bit         conc_phase = 0;
  int         n_chk = 0, n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic ent_t mk(input bit err, input bit last, input logic [7:0] d);
    ent_t e;
    e.err = err; e.last = last; e.data = d;
    return e;
  endfunction

  // One clkdiv cycle: present a byte, then apply the frame model for that edge.
  task automatic drive(input logic [7:0] b, input logic ad, input role_e r);
    int pre;
    bit pop, push, bad;
    q_in = b;
    align_done = ad;
    @(posedge clkdiv);
    #1;
    pre = mcount;
    pop = m_ready && (pre > 0);
    push = 0;
    exp_good = 0; exp_bad = 0; exp_ovf = 0;
    case (r)
      R_SOF:    begin f_pushed = 0; f_dropped = 0; end
      R_LENBAD: exp_bad = 1;
      R_PAY: begin
        if (pre < DEPTH - 1) begin
          exp_q.push_back(mk(0, 0, b)); push = 1; f_pushed = 1;
        end else begin
          exp_ovf = 1; f_dropped = 1;
        end
      end
      R_CHK: begin
        bad = f_dropped || (b != f_sum);
        if (f_pushed) begin exp_q.push_back(mk(bad, 1, b)); push = 1; end
        exp_good = !bad; exp_bad = bad;
      end
      R_ABORT: begin
        if (f_pushed) begin exp_q.push_back(mk(1, 1, 8'h00)); push = 1; end
        exp_bad = 1;
      end
      default: ;
    endcase
    tot_good += int'(exp_good); tot_bad += int'(exp_bad); tot_ovf += int'(exp_ovf);
    mcount = pre + int'(push) - int'(pop);
    case (rdy_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(1));
    endcase
  endtask

  function automatic logic [7:0] rnd_fill();
    logic [7:0] b;
    do b = 8'($urandom); while (b == SOF);
    return b;
  endfunction

  // Sends SOF, LEN, payload from pay_q (random if empty), CHK.
  // corrupt flips the checksum; abort_at: -1 none, -2 at LEN, k in 0..len at
  // the k-th byte after LEN (len == CHK position).
  task automatic send_frame(input int len, input bit corrupt, input int abort_at);
    logic [7:0] b;
    drive(SOF, 1, R_SOF);
    if (abort_at == -2) begin drive(8'(len), 0, R_ABORT); return; end
    drive(8'(len), 1, R_LEN);
    f_sum = 8'(len);
    for (int i = 0; i < len; i++) begin
      if (abort_at == i) begin drive(8'($urandom), 0, R_ABORT); pay_q.delete(); return; end
      b = (pay_q.size() > 0) ? pay_q.pop_front() : 8'($urandom);
      f_sum ^= b;
      drive(b, 1, R_PAY);
    end
    if (abort_at == len) begin drive(8'($urandom), 0, R_ABORT); return; end
    drive(corrupt ? (f_sum ^ 8'h01) : f_sum, 1, R_CHK);
  endtask

  // After an abort: bytes are ignored while unlocked, then relock.
  task automatic relock();
    drive(SOF, 0, R_IGN);
    drive(8'h03, 0, R_IGN);
    drive(8'h11, 0, R_IGN);
    drive(8'hFF, 1, R_IGN);
  endtask

  task automatic drain();
    int n = 0;
    rdy_mode = 1;
    m_ready = 1'b1;
    while (mcount > 0 && n < 200) begin drive(8'hFF, 1, R_IGN); n++; end
    check("drain_done", mcount, 0);
  endtask

  always @(negedge clkdiv) begin
    if (mon_en) begin
      ent_t e;
      check("frame_good", int'(frame_good), int'(exp_good));
      check("frame_bad", int'(frame_bad), int'(exp_bad));
      check("overflow", int'(overflow), int'(exp_ovf));
      check("fifo_count", int'(fifo_count), mcount);
      check("m_valid", int'(m_valid), int'(mcount > 0));
      if (conc_phase) check("conc_count_le1", int'(fifo_count <= 1), 1);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_entry", int'({m_err, m_last, m_data}), -1);
        else begin
          e = exp_q.pop_front();
          check("entry", int'({m_err, m_last, m_data}), int'(e));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, kind, ab;
    rst = 1'b1; q_in = 8'h00; align_done = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clkdiv);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_fifo_count", int'(fifo_count), 0);
    check("rst_pulses", int'({frame_good, frame_bad, overflow}), 0);
    rst = 1'b0;
    #1 mon_en = 1;

    // Unlocked: even a full-looking frame is ignored.
    drive(SOF, 0, R_IGN); drive(8'h03, 0, R_IGN); drive(8'h11, 0, R_IGN);
    drive(8'hFF, 1, R_IGN);

    // Good frame, then bad checksum, both held then drained.
    drive(8'hFF, 1, R_IGN); drive(8'h0A, 1, R_IGN);
    pay_q = '{8'h11, 8'h22, 8'h33};
    send_frame(3, 0, -1);
    drain();
    rdy_mode = 0;
    pay_q = '{8'h11, 8'h22, 8'h33};
    send_frame(3, 1, -1);
    drain();

    // Illegal lengths, then a good frame.
    rdy_mode = 0;
    drive(SOF, 1, R_SOF); drive(8'h00, 1, R_LENBAD);
    drive(SOF, 1, R_SOF); drive(8'(MAXL + 1), 1, R_LENBAD);
    send_frame(MAXL, 0, -1);
    drain();

    // Overflow with consumer stalled.
    rdy_mode = 0; m_ready = 1'b0;
    send_frame(20, 0, -1);
    check("ovf_count_full", int'(mcount), DEPTH);
    drain();

    // Abort after two payload bytes.
    rdy_mode = 0;
    send_frame(5, 0, 2);
    relock();
    drain();

    // Concurrent push/pop keeps the FIFO at one entry at most.
    rdy_mode = 1; m_ready = 1'b1;
    conc_phase = 1;
    send_frame(8, 0, -1);
    drive(8'hFF, 1, R_IGN);
    conc_phase = 0;

    // Reset mid-frame empties the FIFO without pulses.
    rdy_mode = 0; m_ready = 1'b0;
    drive(SOF, 1, R_SOF); drive(8'h05, 1, R_LEN);
    drive(8'h01, 1, R_PAY); drive(8'h02, 1, R_PAY);
    mon_en = 0;
    rst = 1'b1;
    #1;
    check("midrst_count", int'(fifo_count), 0);
    check("midrst_valid", int'(m_valid), 0);
    exp_q.delete(); mcount = 0; exp_good = 0; exp_bad = 0; exp_ovf = 0;
    @(negedge clkdiv);
    check("midrst_pulses", int'({frame_good, frame_bad, overflow}), 0);
    rst = 1'b0;
    #1 mon_en = 1;
    drive(8'hFF, 1, R_IGN);

    // Randomized traffic.
    rdy_mode = 2;
    for (int f = 0; f < 150; f++) begin
      repeat ($urandom_range(3)) drive(rnd_fill(), 1, R_IGN);
      kind = $urandom_range(9);
      len = $urandom_range(MAXL, 1);
      if (kind == 0) begin
        drive(SOF, 1, R_SOF);
        drive(($urandom_range(1) == 0) ? 8'h00 : 8'($urandom_range(255, MAXL + 1)), 1, R_LENBAD);
      end else if (kind == 1) begin
        ab = int'($urandom_range(len + 1)) - 2;
        if (ab == -1) ab = 0;
        send_frame(len, 0, ab);
        relock();
      end else begin
        send_frame(len, kind == 2, -1);
      end
    end
    drain();
    check("scoreboard_empty", exp_q.size(), 0);
`ifdef C2C_RX_STATS_EN
    check("stat_good", int'(stat_good), tot_good);
    check("stat_bad", int'(stat_bad), tot_bad);
    check("stat_drop", int'(stat_drop), tot_ovf);
`endif
    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
